sram_ctrl_param: RTL and testbench

SRAM_CTRL_PARAM -- requirements
Module: sram_ctrl_param

---
 rtl/sram_ctrl_param.sv | 183 ++++++++++++++++++
 tb/tb_sram_ctrl_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_param.sv
// Asynchronous SRAM controller: byte/half/word loads and stores with lane steering and extension.
// Optional macro SRAM_CTRL_TURNAROUND_EN adds a TA bus-turnaround cycle after each completed access.
module sram_ctrl_param #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1,
  localparam int NB     = DATA_W / 8,
  localparam int OFS    = $clog2(DATA_W / 8)
) (
  input  logic                  clk50,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  sext_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [ADDR_W-OFS-1:0] sram_addr_o,
  inout  wire  [DATA_W-1:0]     sram_data_io,
  output logic                  sram_ce_n_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_we_n_o,
  output logic [NB-1:0]         sram_be_n_o
);

`ifdef SRAM_CTRL_TURNAROUND_EN
  typedef enum logic [2:0] {IDLE, RD, RD_END, WR_SETUP, WR_PULSE, WR_HOLD, DONE, TA} state_t;
  localparam state_t POST_ST = TA;
`else
  typedef enum logic [2:0] {IDLE, RD, RD_END, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;
  localparam state_t POST_ST = IDLE;
`endif

  state_t              r_state, w_state_next;
  logic [15:0]         r_cnt, w_cnt_next;
  logic [1:0]          r_size;
  logic                r_sext;
  logic [OFS-1:0]      r_off;
  logic [NB-1:0]       r_be_wr;
  logic [DATA_W-1:0]   r_wbus;
  logic                r_drive;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ack, r_err, r_busy;
  logic                r_ce_n, r_oe_n, r_we_n;
  logic [NB-1:0]       r_be_n;
  logic [ADDR_W-OFS-1:0] r_saddr;

  logic                w_bad;
  logic                w_accept;
  logic                w_next_wr;
  logic [NB-1:0]       w_be_in;
  logic [DATA_W-1:0]   w_wbus_in;
  logic [DATA_W-1:0]   w_rd_sh;
  logic [DATA_W-1:0]   w_rd_ext;
  logic                w_sign;

  assign w_bad = (size_i == 2'd3)
               || (size_i == 2'd1 && addr_i[0])
               || (size_i == 2'd2 && ((DATA_W == 16) || (addr_i[OFS-1:0] != '0)));

  // A lane is enabled when it shares the access-sized block with the addressed byte.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      localparam logic [OFS-1:0] LANE = OFS'(gi);
      assign w_be_in[gi] = !((LANE >> size_i) == (addr_i[OFS-1:0] >> size_i));
      assign w_wbus_in[8*gi +: 8] = (size_i == 2'd0) ? wdata_i[7:0] :
                                    (size_i == 2'd1) ? wdata_i[8*(gi%2) +: 8] :
                                                       wdata_i[8*gi +: 8];
    end
  endgenerate

  assign w_rd_sh = sram_data_io >> {r_off, 3'b000};
  assign w_sign  = r_sext & ((r_size == 2'd1) ? w_rd_sh[15] : w_rd_sh[7]);

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ext
      assign w_rd_ext[gi] = (gi < 8 || r_size == 2'd2 || (r_size == 2'd1 && gi < 16))
                            ? w_rd_sh[gi] : w_sign;
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_i) begin
          w_accept = 1'b1;
          if (w_bad) begin
            w_state_next = DONE;
          end else if (we_i) begin
            w_state_next = WR_SETUP;
          end else begin
            w_state_next = RD;
            w_cnt_next   = 16'(RD_WAIT - 1);
          end
        end
      end
      RD: begin
        if (r_cnt == 16'd0) w_state_next = RD_END;
        else                w_cnt_next   = r_cnt - 16'd1;
      end
      RD_END:   w_state_next = POST_ST;
      WR_SETUP: begin
        w_state_next = WR_PULSE;
        w_cnt_next   = 16'(WR_WAIT - 1);
      end
      WR_PULSE: begin
        if (r_cnt == 16'd0) w_state_next = WR_HOLD;
        else                w_cnt_next   = r_cnt - 16'd1;
      end
      WR_HOLD:  w_state_next = DONE;
      DONE:     w_state_next = POST_ST;
      default:  w_state_next = IDLE;
    endcase
  end

  assign w_next_wr = (w_state_next == WR_SETUP) || (w_state_next == WR_PULSE)
                   || (w_state_next == WR_HOLD);

  // Every pin-facing signal is decoded from the next state so it lines up with r_state.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_size  <= '0;
      r_sext  <= 1'b0;
      r_off   <= '0;
      r_be_wr <= '1;
      r_wbus  <= '0;
      r_drive <= 1'b0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_be_n  <= '1;
      r_saddr <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept && !w_bad) begin
        r_size  <= size_i;
        r_sext  <= sext_i;
        r_off   <= addr_i[OFS-1:0];
        r_be_wr <= w_be_in;
        r_wbus  <= w_wbus_in;
        r_saddr <= addr_i[ADDR_W-1:OFS];
      end
      if (r_state == RD && r_cnt == 16'd0) r_rdata <= w_rd_ext;
      r_ack   <= (w_state_next == RD_END) || (w_state_next == DONE);
      r_err   <= w_accept && w_bad;
      r_busy  <= (w_state_next != IDLE);
      r_ce_n  <= !((w_state_next == RD) || w_next_wr);
      r_oe_n  <= !(w_state_next == RD);
      r_we_n  <= !(w_state_next == WR_PULSE);
      r_drive <= w_next_wr;
      if (w_state_next == RD)  r_be_n <= '0;
      else if (w_next_wr)      r_be_n <= (r_state == IDLE) ? w_be_in : r_be_wr;
      else                     r_be_n <= '1;
    end
  end

  assign sram_data_io = r_drive ? r_wbus : 'z;
  assign rdata_o      = r_rdata;
  assign ack_o        = r_ack;
  assign err_o        = r_err;
  assign busy_o       = r_busy;
  assign sram_addr_o  = r_saddr;
  assign sram_ce_n_o  = r_ce_n;
  assign sram_oe_n_o  = r_oe_n;
  assign sram_we_n_o  = r_we_n;
  assign sram_be_n_o  = r_be_n;

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Directed bench for sram_ctrl_param with a small behavioural SRAM on the shared bus.
module tb_sram_ctrl_param;
  logic        clk50 = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'd0;
  logic        sext_i = 1'b0;
  logic [21:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        ack_o, err_o, busy_o;
  logic [19:0] sram_addr_o;
  tri1  [31:0] sram_data_io;
  logic        sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [3:0]  sram_be_n_o;

  int n_checks = 0;
  int n_errors = 0;
  int oe_viol  = 0;
  logic [31:0] mem [16];

`ifdef SRAM_CTRL_TURNAROUND_EN
  localparam int TA_CYC = 1;
`else
  localparam int TA_CYC = 0;
`endif

  sram_ctrl_param dut (
    .clk50(clk50), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .sext_i(sext_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o), .sram_addr_o(sram_addr_o),
    .sram_data_io(sram_data_io), .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
    .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o)
  );

  always #10 clk50 = ~clk50;

  assign sram_data_io = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[3:0]] : 'z;

  always @(posedge clk50) begin
    if (!sram_ce_n_o && !sram_we_n_o) begin
      for (int l = 0; l < 4; l++)
        if (!sram_be_n_o[l]) mem[sram_addr_o[3:0]][8*l +: 8] <= sram_data_io[8*l +: 8];
    end
  end

  always @(negedge clk50) if (!sram_oe_n_o && !sram_we_n_o) oe_viol++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic wait_idle();
    @(negedge clk50);
    for (int i = 0; i < 20 && busy_o; i++) @(negedge clk50);
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic sx,
                      input logic [21:0] a, input logic [31:0] wd,
                      output int lat, output logic er, output logic [3:0] be,
                      output int we_lo, output int ce_lo, output logic [31:0] wbus,
                      output logic [19:0] sa);
    logic got;
    wait_idle();
    req_i = 1'b1; we_i = we; size_i = sz; sext_i = sx; addr_i = a; wdata_i = wd;
    lat = 0; er = 1'b0; be = 4'hF; we_lo = 0; ce_lo = 0; wbus = '0; sa = '0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk50); #1;
      lat++;
      if (!sram_ce_n_o) begin ce_lo++; be = sram_be_n_o; sa = sram_addr_o; end
      if (!sram_we_n_o) begin we_lo++; wbus = sram_data_io; end
      if (ack_o) begin got = 1'b1; er = err_o; req_i = 1'b0; end
    end
    req_i = 1'b0;
    @(posedge clk50); #1;
    check("ack_single_cycle", {31'b0, ack_o}, 32'h0);
  endtask

  int lat, we_lo, ce_lo, acks;
  logic er;
  logic [3:0] be;
  logic [31:0] wbus;
  logic [19:0] sa;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(posedge clk50);
    #1;
    check("rst_ack_err_busy", {29'b0, ack_o, err_o, busy_o}, 32'h0);
    check("rst_strobes", {25'b0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o}, 32'h7F);
    check("rst_addr", {12'b0, sram_addr_o}, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_bus_released", sram_data_io, 32'hFFFFFFFF);
    @(negedge clk50); rst_n = 1'b1;

    xact(1'b1, 2'd2, 1'b0, 22'h10, 32'hDEADBEEF, lat, er, be, we_lo, ce_lo, wbus, sa);
    check("sw_latency", lat, 32'd4);
    check("sw_err", {31'b0, er}, 32'h0);
    check("sw_we_low_cycles", we_lo, 32'd1);
    check("sw_ce_low_cycles", ce_lo, 32'd3);
    check("sw_be_n", {28'b0, be}, 32'h0);
    check("sw_sram_addr", {12'b0, sa}, 32'h4);
    check("sw_bus_data", wbus, 32'hDEADBEEF);

    xact(1'b0, 2'd2, 1'b0, 22'h10, 32'h0, lat, er, be, we_lo, ce_lo, wbus, sa);
    check("lw_latency", lat, 32'd3);
    check("lw_ce_low_cycles", ce_lo, 32'd2);
    check("lw_be_n", {28'b0, be}, 32'h0);
    check("lw_rdata", rdata_o, 32'hDEADBEEF);

    xact(1'b1, 2'd0, 1'b0, 22'h13, 32'h00000080, lat, er, be, we_lo, ce_lo, wbus, sa);
    check("sb_be_n", {28'b0, be}, 32'h7);
    check("sb_bus_replicated", wbus, 32'h80808080);

    xact(1'b0, 2'd0, 1'b1, 22'h13, 32'h0, lat, er, be, we_lo, ce_lo, wbus, sa);
    check("lb_sext_rdata", rdata_o, 32'hFFFFFF80);
    xact(1'b0, 2'd0, 1'b0, 22'h13, 32'h0, lat, er, be, we_lo, ce_lo, wbus, sa);
    check("lb_zext_rdata", rdata_o, 32'h00000080);
    xact(1'b0, 2'd2, 1'b0, 22'h10, 32'h0, lat, er, be, we_lo, ce_lo, wbus, sa);
    check("lw_after_sb", rdata_o, 32'h80ADBEEF);
    xact(1'b0, 2'd1, 1'b1, 22'h12, 32'h0, lat, er, be, we_lo, ce_lo, wbus, sa);
    check("lh_sext_rdata", rdata_o, 32'hFFFF80AD);

    xact(1'b1, 2'd1, 1'b0, 22'h16, 32'h00001234, lat, er, be, we_lo, ce_lo, wbus, sa);
    check("sh_be_n", {28'b0, be}, 32'h3);
    check("sh_bus_replicated", wbus, 32'h12341234);
    xact(1'b0, 2'd2, 1'b0, 22'h14, 32'h0, lat, er, be, we_lo, ce_lo, wbus, sa);
    check("lw_after_sh", rdata_o, 32'h12340000);

    xact(1'b0, 2'd1, 1'b0, 22'h01, 32'h0, lat, er, be, we_lo, ce_lo, wbus, sa);
    check("misalign_half_latency", lat, 32'd1);
    check("misalign_half_err", {31'b0, er}, 32'h1);
    check("misalign_half_no_ce", ce_lo, 32'd0);
    check("rdata_held_after_err", rdata_o, 32'h12340000);
    xact(1'b0, 2'd3, 1'b0, 22'h10, 32'h0, lat, er, be, we_lo, ce_lo, wbus, sa);
    check("size3_latency", lat, 32'd1);
    check("size3_err", {31'b0, er}, 32'h1);
    check("size3_no_ce", ce_lo, 32'd0);
    xact(1'b1, 2'd2, 1'b0, 22'h12, 32'h55555555, lat, er, be, we_lo, ce_lo, wbus, sa);
    check("misalign_word_err", {31'b0, er}, 32'h1);
    check("misalign_word_no_ce", ce_lo, 32'd0);

    // Store immediately followed by a load with req_i held through the ack.
    wait_idle();
    req_i = 1'b1; we_i = 1'b1; size_i = 2'd2; sext_i = 1'b0; addr_i = 22'h18; wdata_i = 32'hCAFEF00D;
    acks = 0;
    for (int i = 0; i < 20 && acks == 0; i++) begin
      @(posedge clk50); #1;
      if (ack_o) acks++;
    end
    check("b2b_store_ack", acks, 32'd1);
    we_i = 1'b0;
    lat = 0; acks = 0;
    for (int i = 0; i < 20 && acks == 0; i++) begin
      @(posedge clk50); #1;
      lat++;
      if (lat == 1) begin
        check("b2b_no_double_ack", {31'b0, ack_o}, 32'h0);
        check("b2b_gap_strobes", {29'b0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o}, 32'h7);
      end
      if (ack_o) acks++;
    end
    req_i = 1'b0;
    check("b2b_load_latency", lat, 32'(4 + TA_CYC));
    check("b2b_load_rdata", rdata_o, 32'hCAFEF00D);

    // Reset asserted in the middle of the write pulse.
    wait_idle();
    req_i = 1'b1; we_i = 1'b1; size_i = 2'd2; addr_i = 22'h20; wdata_i = 32'h12345678;
    @(posedge clk50); #1;
    req_i = 1'b0;
    @(posedge clk50); #1;
    check("rst_mid_we_low", {31'b0, sram_we_n_o}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_bus_z", sram_data_io, 32'hFFFFFFFF);
    check("rst_mid_strobes", {25'b0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o}, 32'h7F);
    check("rst_mid_ack_busy", {30'b0, ack_o, busy_o}, 32'h0);
    @(negedge clk50); @(negedge clk50); rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk50); #1;
      if (ack_o) acks++;
    end
    check("rst_mid_no_ack", acks, 32'd0);
    xact(1'b0, 2'd2, 1'b0, 22'h10, 32'h0, lat, er, be, we_lo, ce_lo, wbus, sa);
    check("post_rst_latency", lat, 32'd3);
    check("post_rst_rdata", rdata_o, 32'h80ADBEEF);

    check("oe_low_with_we_low", oe_viol, 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end
endmodule
